// File: rtl/led_scanner.sv
// led_scanner: multiplexed seven-segment driver for the board display.
// clk_led is the scan-rate reference from the clock generator. It is
// synchronised, and each of its rising edges advances the lit digit.
// Digit data is latched once per frame so the display does not tear.
// After each digit switch, all anodes are held off for a short time to
// suppress ghosting on the display.

module led_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_board,
    input  logic                    rst_n,
    input  logic                    clk_led,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n
);

    localparam int                IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]        BLANK_LOAD = 8'(BLANK_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;
    localparam logic [6:0]        SEG_OFF    = 7'h7F;

    // Segment pattern (gfedcba, active-low) for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    edge_q;
    logic                    tick;

    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_next;
    logic                    frame_start;

    logic [4*NUM_DIGITS-1:0] shadow_data_q;
    logic [NUM_DIGITS-1:0]   shadow_en_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;

    logic [7:0]              blank_cnt_q;
    logic                    blank_done;

    logic [3:0]              cur_nibble;
    logic                    cur_en;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   an_drive;
    logic [6:0]              seg_drive;
    logic                    dp_n_drive;

    // Bring clk_led into clk_board, then remember the last synchronised level.
    always_ff @(posedge clk_board) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_led};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A scan tick is a synchronised rising edge; falling edges are ignored.
    assign tick = sync_q[SYNC_STAGES-1] & ~edge_q;

    // Select the next digit index and detect the start of a new frame.
    always_comb begin
        idx_next    = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        frame_start = tick & (idx_q == LAST_IDX);
    end

    // Advance the lit digit once per tick, wrapping after the last digit.
    always_ff @(posedge clk_board) begin
        if (!rst_n) begin
            idx_q <= LAST_IDX;
        end else if (tick) begin
            idx_q <= idx_next;
        end
    end

    // Latch a full frame of display data when the scan returns to digit 0.
    always_ff @(posedge clk_board) begin
        if (!rst_n) begin
            shadow_data_q <= '0;
            shadow_en_q   <= '0;
            shadow_dp_q   <= '0;
        end else if (frame_start) begin
            shadow_data_q <= data;
            shadow_en_q   <= digit_en;
            shadow_dp_q   <= dp;
        end
    end

    // Blanking down-counter: reload on every tick, count down to zero.
    always_ff @(posedge clk_board) begin
        if (!rst_n) begin
            blank_cnt_q <= '0;
        end else if (tick) begin
            blank_cnt_q <= BLANK_LOAD;
        end else if (blank_cnt_q != 8'd0) begin
            blank_cnt_q <= blank_cnt_q - 8'd1;
        end
    end

    // The terminal count is observed the cycle after the counter hits zero,
    // so the digit appears BLANK_CYCLES+1 cycles after the index moved.
    assign blank_done = (blank_cnt_q == 8'd0);

    // Form the drive pattern for the current digit from the frame shadow.
    always_comb begin
        cur_nibble = shadow_data_q[{idx_q, 2'b00} +: 4];
        cur_en     = shadow_en_q[idx_q];
        cur_dp     = shadow_dp_q[idx_q];
        an_drive   = AN_OFF;
        seg_drive  = SEG_OFF;
        dp_n_drive = 1'b1;
        if (cur_en) begin
            an_drive   = ~(NUM_DIGITS'(1) << idx_q);
            seg_drive  = hex_to_seg(cur_nibble);
            dp_n_drive = ~cur_dp;
        end
    end

    // Register the outputs: all off on a tick or while blanking, else the digit.
    always_ff @(posedge clk_board) begin
        if (!rst_n) begin
            an   <= AN_OFF;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else if (tick || !blank_done) begin
            an   <= AN_OFF;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_drive;
            seg  <= seg_drive;
            dp_n <= dp_n_drive;
        end
    end

endmodule

// File: tb/tb_led_scanner.sv
// Bench for led_scanner. A reference model checks the outputs every cycle.
// The model is written in terms of "rising edges seen on clk_led" and
// "cycles since the last digit switch".

module tb_led_scanner;

    localparam int N = 8;
    localparam int B = 16;
    localparam int S = 2;

    logic           clk_board = 1'b0;
    logic           rst_n     = 1'b0;
    logic           clk_led   = 1'b0;
    logic [4*N-1:0] data      = '0;
    logic [N-1:0]   digit_en  = '0;
    logic [N-1:0]   dp        = '0;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           dp_n;

    led_scanner #(
        .NUM_DIGITS  (N),
        .BLANK_CYCLES(B),
        .SYNC_STAGES (S)
    ) dut (
        .clk_board(clk_board),
        .rst_n    (rst_n),
        .clk_led  (clk_led),
        .data     (data),
        .digit_en (digit_en),
        .dp       (dp),
        .an       (an),
        .seg      (seg),
        .dp_n     (dp_n)
    );

    always #5 clk_board = ~clk_board;

    int total = 0;
    int bad   = 0;

    logic [6:0] hex_tab [0:15];

    // reference model state
    bit             samples[$];
    int             m_idx;
    int             since;
    int             ticks;
    logic [4*N-1:0] sh_data;
    logic [N-1:0]   sh_en;
    logic [N-1:0]   sh_dp;
    logic [N-1:0]   e_an;
    logic [6:0]     e_seg;
    logic           e_dp_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // Model one clk_board edge, using the input values the DUT sampled.
    task automatic model_edge();
        bit tick;
        int n;
        if (!rst_n) begin
            samples.delete();
            m_idx   = N - 1;
            since   = 1000;
            sh_data = '0;
            sh_en   = '0;
            sh_dp   = '0;
        end else begin
            // A level is acted on S edges after the edge that first samples it.
            n    = samples.size();
            tick = (n >= S) && samples[n-S] && ((n - S - 1 < 0) || !samples[n-S-1]);
            samples.push_back(clk_led);
            if (tick) begin
                ticks++;
                m_idx = (m_idx + 1) % N;
                if (m_idx == 0) begin
                    sh_data = data;
                    sh_en   = digit_en;
                    sh_dp   = dp;
                end
                since = 0;
            end else if (since < 1000) begin
                since++;
            end
        end
        e_an   = '1;
        e_seg  = 7'h7F;
        e_dp_n = 1'b1;
        if (rst_n && since >= B + 1 && sh_en[m_idx]) begin
            e_an       = '1;
            e_an[m_idx] = 1'b0;
            e_seg      = hex_tab[sh_data[4*m_idx +: 4]];
            e_dp_n     = ~sh_dp[m_idx];
        end
    endtask

    task automatic cycle();
        @(posedge clk_board);
        model_edge();
        @(negedge clk_board);
        check("an",   32'(an),   32'(e_an));
        check("seg",  32'(seg),  32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dp_n));
    endtask

    task automatic hold(input logic level, input int ncyc);
        clk_led = level;
        repeat (ncyc) cycle();
    endtask

    task automatic led_pulse(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    initial begin
        hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        ticks = 0;
        m_idx = N - 1;
        since = 1000;

        // reset with clk_led toggling
        @(negedge clk_board);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_led = ~clk_led;
            cycle();
        end
        clk_led = 1'b0;
        rst_n   = 1'b1;
        hold(1'b0, 6);
        check("no_tick_after_reset", 32'(ticks), 32'd0);

        // frame load, then scan through the full frame and wrap
        data     = 32'h76543210;
        digit_en = 8'hFF;
        dp       = 8'h01;
        led_pulse(30, 20);
        check("digit0_an",  32'(an),   32'h000000FE);
        check("digit0_seg", 32'(seg),  32'(7'b1000000));
        check("digit0_dp",  32'(dp_n), 32'd0);
        repeat (3) led_pulse(25, 25);
        check("digit3_an", 32'(an), 32'h000000F7);
        data = 32'hFFFFFFFF;
        repeat (4) led_pulse(25, 25);
        check("digit7_seg", 32'(seg), 32'(7'b1111000));
        led_pulse(25, 25);
        check("wrap_seg", 32'(seg), 32'(7'b0001110));
        check("wrap_an",  32'(an),  32'h000000FE);

        // blanking mask on digit 1
        data     = 32'h89ABCDEF;
        digit_en = 8'hFD;
        repeat (10) led_pulse(22, 22);

        // fast ticks: digits never visible, then reset mid-blank
        begin
            int t0;
            t0 = ticks;
            repeat (20) led_pulse(3, 3);
            check("fast_tick_count", 32'(ticks - t0), 32'd20);
        end
        hold(1'b1, 4);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        hold(1'b0, 30);

        // clk_led held high across reset release, then stuck high
        data     = 32'h0F1E2D3C;
        digit_en = 8'hFF;
        dp       = 8'hA5;
        rst_n    = 1'b0;
        hold(1'b1, 3);
        rst_n = 1'b1;
        hold(1'b1, 200);
        check("stuck_digit0_an", 32'(an), 32'h000000FE);

        // randomized scanning with random data, masks and occasional resets
        for (int r = 0; r < 150; r++) begin
            if ($urandom_range(0, 3) == 0) data     = $urandom;
            if ($urandom_range(0, 5) == 0) digit_en = N'($urandom);
            if ($urandom_range(0, 5) == 0) dp       = N'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end
            hold(~clk_led, $urandom_range(1, 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
